// File: rtl/shared_umul_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared unsigned multiplier.
// Widths are sized for the largest supported configuration; callers slice down.
package shared_umul_arbiter_pkg;

    localparam int MAX_N_REQ = 16;
    localparam int MAX_TAG_W = 4;
    localparam int MAX_P_W   = 64;

    typedef struct packed {
        logic [MAX_N_REQ-1:0] grant;
        logic [MAX_TAG_W-1:0] idx;
    } pick_t;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [MAX_P_W-1:0]   product;
    } stage_t;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req searching upward from ptr+1, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_N_REQ-1:0] req,
                                      input logic [MAX_TAG_W-1:0] ptr,
                                      input int                   n);
        pick_t                r;
        logic [MAX_TAG_W-1:0] idx;
        logic                 hit;
        r   = '0;
        hit = 1'b0;
        for (int k = 1; k <= MAX_N_REQ; k++) begin
            idx = MAX_TAG_W'((int'(ptr) + k) % n);
            if (k <= n && !hit && req[idx]) begin
                hit          = 1'b1;
                r.grant[idx] = 1'b1;
                r.idx        = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_umul_arbiter_if.sv
// Request/response bundle between requesters (master) and the shared multiplier (slave).
interface shared_umul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int A_W   = 3,
    parameter int B_W   = 8,
    parameter int P_W   = 9
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     rsp_valid;
    logic [N_REQ-1:0]     rsp_ready;
    logic [N_REQ*P_W-1:0] rsp_data;
    logic [N_REQ-1:0]     busy;
    logic                 ap_idle;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy, ap_idle
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy, ap_idle
    );
endinterface

// File: rtl/shared_umul_pipe.sv
// Truncating unsigned multiplier with MUL_STAGES output registers carrying valid and tag.
// With MUL_STAGES=0 the path is purely combinational.
module shared_umul_pipe
    import shared_umul_arbiter_pkg::*;
#(
    parameter int A_W        = 3,
    parameter int B_W        = 8,
    parameter int P_W        = 9,
    parameter int TAG_W      = 2,
    parameter int MUL_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output stage_t           out_stage
);
    localparam int F_W = A_W + B_W;

    logic [F_W-1:0] full_product;
    logic [P_W-1:0] trunc_product;
    stage_t         head;

    always_comb begin
        full_product  = F_W'(in_a) * F_W'(in_b);
        trunc_product = P_W'(full_product);
        head          = '0;
        head.valid    = in_valid;
        head.tag      = MAX_TAG_W'(in_tag);
        head.product  = MAX_P_W'(trunc_product);
    end

    generate
        if (MUL_STAGES == 0) begin : g_comb
            assign out_stage = head;
        end else begin : g_piped
            stage_t stage_reg [MUL_STAGES];
            for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) stage_reg[gi] <= '0;
                        else     stage_reg[gi] <= head;
                    end
                end else begin : g_next
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) stage_reg[gi] <= '0;
                        else     stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
            assign out_stage = stage_reg[MUL_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/shared_umul_arbiter.sv
// Round-robin arbiter sharing one truncating multiplier among N_REQ requesters,
// with a one-entry response buffer and busy flag per requester.
module shared_umul_arbiter
    import shared_umul_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int A_W        = 3,
    parameter int B_W        = 8,
    parameter int P_W        = 9,
    parameter int MUL_STAGES = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    shared_umul_arbiter_if.slave  bus
);
    localparam int TAG_W = tag_width(N_REQ);

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] busy_reg;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic [N_REQ-1:0] rsp_fire;
    logic [N_REQ-1:0] wr_en;
    logic [TAG_W-1:0] ptr_reg;
    logic [TAG_W-1:0] sel_idx;
    logic [A_W-1:0]   sel_a;
    logic [B_W-1:0]   sel_b;
    pick_t            pick;
    stage_t           pipe_out;
    logic             unused_bits;

    always_comb begin
        elig    = bus.req_valid & ~busy_reg;
        pick    = rr_pick(MAX_N_REQ'(elig), MAX_TAG_W'(ptr_reg), N_REQ);
        grant   = pick.grant[N_REQ-1:0];
        sel_idx = pick.idx[TAG_W-1:0];
        sel_a   = bus.req_a[sel_idx*A_W +: A_W];
        sel_b   = bus.req_b[sel_idx*B_W +: B_W];
    end

    // Upper bits of the max-width package records are structurally zero.
    assign unused_bits = ^{pick.grant, pick.idx, pipe_out.product};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)      ptr_reg <= TAG_W'(N_REQ - 1);
        else if (|grant) ptr_reg <= sel_idx;
    end

    shared_umul_pipe #(
        .A_W        (A_W),
        .B_W        (B_W),
        .P_W        (P_W),
        .TAG_W      (TAG_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_pipe (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (|grant),
        .in_tag    (sel_idx),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_stage (pipe_out)
    );

    assign rsp_fire = rsp_valid_reg & bus.rsp_ready;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic           busy_bit_reg;
            logic           rsp_valid_bit_reg;
            logic [P_W-1:0] rsp_data_reg;

            assign wr_en[gi] = pipe_out.valid && (pipe_out.tag == MAX_TAG_W'(gi));

            // busy blocks re-issue until the buffered result is taken, so a
            // write and a pending result can never collide in this buffer.
            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    busy_bit_reg      <= 1'b0;
                    rsp_valid_bit_reg <= 1'b0;
                    rsp_data_reg      <= '0;
                end else begin
                    if (grant[gi])         busy_bit_reg <= 1'b1;
                    else if (rsp_fire[gi]) busy_bit_reg <= 1'b0;

                    if (wr_en[gi]) begin
                        rsp_valid_bit_reg <= 1'b1;
                        rsp_data_reg      <= pipe_out.product[P_W-1:0];
                    end else if (rsp_fire[gi]) begin
                        rsp_valid_bit_reg <= 1'b0;
                    end
                end
            end

            assign busy_reg[gi]                = busy_bit_reg;
            assign rsp_valid_reg[gi]           = rsp_valid_bit_reg;
            assign bus.rsp_data[gi*P_W +: P_W] = rsp_data_reg;
        end
    endgenerate

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.ap_idle   = ~|busy_reg;

endmodule

// File: tb/tb_shared_umul_arbiter.sv
// Directed + random bench for shared_umul_arbiter with a per-requester result scoreboard.
module tb_shared_umul_arbiter;
    localparam int N_REQ = 4;
    localparam int A_W   = 3;
    localparam int B_W   = 8;
    localparam int P_W   = 9;
    parameter  int MUL_STAGES = 1;

    typedef struct {
        int data;
        int due;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    shared_umul_arbiter_if #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

    shared_umul_arbiter #(
        .N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_STAGES(MUL_STAGES)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    exp_t           sb_q [N_REQ][$];
    int             grant_log[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             cyc   = 0;
    logic [N_REQ-1:0] model_busy = '0;
    logic [N_REQ-1:0] prev_v     = '0;
    logic [N_REQ-1:0] prev_hs    = '0;
    int             prev_data [N_REQ];
    int             held;
    int             others;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model(input int a, input int b);
        return (a * b) % (1 << P_W);
    endfunction

    function automatic int rsp_of(input int i);
        return int'(bus.rsp_data[i*P_W +: P_W]);
    endfunction

    // Called once per cycle at the falling edge.
    task automatic sample();
        logic [N_REQ-1:0] mb_next;
        exp_t e;
        bit   fresh;
        if (ap_rst) begin
            for (int i = 0; i < N_REQ; i++) sb_q[i].delete();
            model_busy = '0;
            prev_v     = '0;
            prev_hs    = '0;
            return;
        end
        chk("grant_onehot0", int'($onehot0(bus.req_ready)), 1);
        chk("busy", int'(bus.busy), int'(model_busy));
        chk("ap_idle", int'(bus.ap_idle), int'(model_busy == '0));
        mb_next = model_busy;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.data = model(int'(bus.req_a[i*A_W +: A_W]), int'(bus.req_b[i*B_W +: B_W]));
                e.due  = cyc + MUL_STAGES + 1;
                sb_q[i].push_back(e);
                grant_log.push_back(i);
                mb_next[i] = 1'b1;
                $display("cycle %0d: accept req %0d a=%0d b=%0d", cyc, i,
                         bus.req_a[i*A_W +: A_W], bus.req_b[i*B_W +: B_W]);
            end
            fresh = bus.rsp_valid[i] && (!prev_v[i] || prev_hs[i]);
            if (fresh) begin
                if (sb_q[i].size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q[i].pop_front();
                    chk("rsp_data", rsp_of(i), e.data);
                    chk("rsp_latency", cyc, e.due);
                    $display("cycle %0d: response req %0d data=%0d", cyc, i, rsp_of(i));
                end
            end else if (bus.rsp_valid[i] && prev_v[i]) begin
                chk("rsp_stable", rsp_of(i), prev_data[i]);
            end
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) mb_next[i] = 1'b0;
            prev_data[i] = rsp_of(i);
        end
        prev_v     = bus.rsp_valid;
        prev_hs    = bus.rsp_valid & bus.rsp_ready;
        model_busy = mb_next;
    endtask

    task automatic tick();
        @(negedge ap_clk);
        sample();
        @(posedge ap_clk);
        cyc++;
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[i*A_W +: A_W] = A_W'(a);
        bus.req_b[i*B_W +: B_W] = B_W'(b);
    endtask

    task automatic issue(input int i, input int a, input int b);
        bit ok;
        set_op(i, a, b);
        bus.req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = bus.req_ready[i];
            tick();
        end
        bus.req_valid[i] = 1'b0;
        chk("issue_grant", int'(ok), 1);
    endtask

    initial begin
        ap_rst        = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        repeat (3) tick();
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_idle", int'(bus.ap_idle), 1);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        ap_rst = 1'b0;
        tick();

        // Single request on requester 2.
        set_op(2, 5, 20);
        bus.req_valid = 4'b0100;
        #1;
        chk("t1_ready", int'(bus.req_ready), 4);
        tick();
        bus.req_valid = '0;
        chk("t1_busy", int'(bus.busy), 4);
        repeat (MUL_STAGES) tick();
        chk("t1_rsp_valid", int'(bus.rsp_valid[2]), 1);
        chk("t1_rsp_data", rsp_of(2), 100);
        tick();
        chk("t1_busy_clear", int'(bus.busy), 0);
        chk("t1_idle", int'(bus.ap_idle), 1);

        // Truncation corners.
        issue(0, 7, 255);
        repeat (MUL_STAGES) tick();
        chk("trunc_7x255", rsp_of(0), 249);
        issue(1, 0, 255);
        repeat (MUL_STAGES) tick();
        chk("trunc_0x255", rsp_of(1), 0);
        issue(3, 2, 255);
        repeat (MUL_STAGES) tick();
        chk("trunc_2x255", rsp_of(3), 510);
        repeat (4) tick();

        // Round robin with all requesters active.
        grant_log.delete();
        for (int i = 0; i < N_REQ; i++) set_op(i, i + 1, 10 * i + 3);
        bus.req_valid = '1;
        repeat (12) tick();
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++)
            chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N_REQ);
        repeat (8) tick();

        // Backpressure on requester 1.
        bus.req_valid = '1;
        bus.rsp_ready = 4'b1101;
        for (int k = 0; k < 20 && !bus.rsp_valid[1]; k++) tick();
        chk("bp_rsp_seen", int'(bus.rsp_valid[1]), 1);
        held = rsp_of(1);
        grant_log.delete();
        repeat (10) begin
            #1;
            chk("bp_no_grant", int'(bus.req_ready[1]), 0);
            tick();
        end
        chk("bp_data_held", rsp_of(1), held);
        others = grant_log.size();
        chk("bp_others_granted", int'(others >= 3), 1);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = '1;
        tick();
        #1;
        chk("bp_regrant", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();

        // Reset while requesters 3 and 0 are in flight.
        bus.req_valid = 4'b1001;
        #1;
        chk("mid_grant3", int'(bus.req_ready), 8);
        tick();
        #1;
        chk("mid_grant0", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        ap_rst = 1'b1;
        repeat (2) tick();
        ap_rst = 1'b0;
        repeat (MUL_STAGES + 3) begin
            chk("mid_no_rsp", int'(bus.rsp_valid), 0);
            chk("mid_busy", int'(bus.busy), 0);
            chk("mid_idle", int'(bus.ap_idle), 1);
            tick();
        end
        bus.req_valid = '1;
        #1;
        chk("mid_first_grant", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();

        // Random traffic, including random response backpressure.
        repeat (400) begin
            bus.req_valid = N_REQ'($urandom);
            bus.req_a     = (N_REQ*A_W)'($urandom);
            bus.req_b     = (N_REQ*B_W)'($urandom);
            bus.rsp_ready = N_REQ'($urandom);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (MUL_STAGES + 10) tick();
        for (int i = 0; i < N_REQ; i++) chk("sb_drained", sb_q[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shared_umul_arbiter.md
Name: shared_umul_arbiter

Overview:
- Shares one unsigned multiplier datapath (A_W x B_W -> P_W, truncating) between N_REQ requesters inside the hls4ml inference path.
- Round-robin arbitration on a valid/ready request interface; one operation is issued per cycle at most.
- The multiplier pipeline carries a requester tag; results return through a one-entry response buffer per requester, with backpressure.
- Each requester has at most one operation outstanding, so buffers can never overflow.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- A_W, 3, operand A width, unsigned.
- B_W, 8, operand B width, unsigned.
- P_W, 9, product width; result is the product mod 2^P_W.
- MUL_STAGES, 1, register stages inside the multiplier (0..4).

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; at most one bit high per cycle.
- req_a  in  N_REQ*A_W  operand A; slice i belongs to requester i.
- req_b  in  N_REQ*B_W  operand B; slice i belongs to requester i.
- rsp_valid  out  N_REQ  per-requester result valid.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  N_REQ*P_W  per-requester result.
- busy  out  N_REQ  requester i has an operation outstanding.
- ap_idle  out  1  high when busy is all zero.

Behaviour:
- Reset (asynchronous, active-high):
  - rsp_valid, rsp_data, busy, pipeline valids all 0; ap_idle=1.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Asserting ap_rst mid-operation discards all in-flight results; no rsp_valid is produced for them after release.
- Eligibility: elig[i] = req_valid[i] & ~busy[i].
- Arbitration:
  - Pick the first eligible index searching from ptr+1 upward, modulo N_REQ.
  - req_ready = one-hot of the pick, or 0 if none eligible.
  - req_ready is combinational from req_valid and registered state; req_valid never depends on req_ready.
- Accept: on req_valid[i]&req_ready[i] at edge T:
  - busy[i] set.
  - ptr := i.
  - a, b and tag i enter the multiplier pipeline.
- Arithmetic: product = zero-extended a * zero-extended b, full width A_W+B_W, then truncated to the low P_W bits. No saturation.
- Latency:
  - rsp_valid[i] rises exactly MUL_STAGES+1 cycles after edge T.
  - The result is written into rsp buffer i. Writing is safe because busy[i] blocks re-issue.
- Response handshake:
  - rsp_data slice i holds stable while rsp_valid[i]=1 and rsp_ready[i]=0.
  - On rsp_valid[i]&rsp_ready[i] at edge, both rsp_valid[i] and busy[i] clear.
- rsp_ready[i] while rsp_valid[i]=0 has no effect.
- Simultaneous events:
  - A response handshake and a new req_valid on the same requester in the same cycle: busy is still 1, so no grant that cycle. The earliest grant is the next cycle.
  - Results for different requesters may complete in the same cycle only through distinct buffers; the pipeline emits one result per cycle maximum.
- Throughput: one accept per cycle when at least MUL_STAGES+2 requesters are active and responses are consumed promptly.
- Pipeline has no stall. Backpressure is handled solely by the busy gating.
- ap_idle = ~|busy, combinational.

Decomposition:
- Shared package holds:
  - TAG_W = max(1, clog2(N_REQ)).
  - The round-robin pick function (request vector, pointer -> one-hot grant and index).
  - A typedef for the pipeline stage record {valid, tag, product}.
- One sub-module: shared_umul_pipe.
  - Unsigned A_W x B_W multiplier, truncated to P_W.
  - MUL_STAGES register stages, with valid and tag carried alongside.
  - Same reset as the parent; with MUL_STAGES=0 it is combinational.
- The parent holds the arbiter, busy flags and response buffers.

Test Plan:
- Reset then single request, MUL_STAGES=1: requester 2 sends a=5, b=20 with rsp_ready=1. Expect req_ready[2] in the same cycle, rsp_valid[2] 2 cycles after accept, rsp_data=100, then busy[2] clears and ap_idle=1.
- Truncation: a=7, b=255 -> rsp_data=249 (1785 mod 512). a=0, b=255 -> 0. a=2, b=255 -> 510.
- Round robin: all four requesters hold valid continuously with rsp_ready=1. Grant order is 0,1,2,3,0,... and each requester's results match its own operands.
- Backpressure: requester 1 holds rsp_ready=0 for 10 cycles. rsp_data[1] stays stable, req_ready[1] stays 0 despite req_valid[1], and other requesters keep being granted. After release, requester 1 is granted the cycle after its handshake.
- Reset mid-flight: ap_rst asserted 1 cycle after accepts on requesters 0 and 3. No rsp_valid appears after release, busy=0, and the first grant after release goes to requester 0.
- MUL_STAGES=0 and MUL_STAGES=4 builds: rsp_valid arrives 1 and 5 cycles after accept respectively, and random operands match a reference model over at least 10k operations.
